tlc_phase_seq: RTL and testbench

Parametrised N-phase traffic light sequencer. It is the next-generation replacement for the fixed 3-phase peak/off-peak controller in the intersection design. Each phase runs GREEN -> YELLOW -> ALLRED from one registered timer. Phase selection is driven by latched sensor demand in off-peak mode and is fixed round-robin in peak mode. Mirrored signal heads (opposite approaches) are wired outside this block from the per-phase light bus.

---
 rtl/tlc_phase_seq.sv | 163 ++++++++++++++++
 tb/tb_tlc_phase_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_seq.sv
// N-phase traffic light sequencer: GREEN -> YELLOW -> ALLRED per phase,
// one shared timer, demand-driven phase skipping off-peak, round-robin in peak.
module tlc_phase_seq #(
  parameter int NUM_PHASES = 3,
  parameter int TW         = 6,
  parameter int G_PEAK     = 32,
  parameter int G_OFF      = 16,
  parameter int YEL        = 4,
  parameter int ALLRED     = 4,
  parameter logic [NUM_PHASES-1:0] MINOR_MASK = 3'b100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    peak,
  input  logic [NUM_PHASES-1:0]   sensor,
  output logic [2*NUM_PHASES-1:0] lights,
  output logic [2:0]              phase,
  output logic [1:0]              state,
  output logic                    cycle_start
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  // Exit compares are against duration-1 so a state lasts exactly its duration.
  localparam logic [TW-1:0] GP_LAST       = TW'(G_PEAK - 1);
  localparam logic [TW-1:0] GP_MINOR_LAST = TW'((G_PEAK >> 1) - 1);
  localparam logic [TW-1:0] GO_LAST       = TW'(G_OFF - 1);
  localparam logic [TW-1:0] GO_MINOR_LAST = TW'((G_OFF >> 1) - 1);
  localparam logic [TW-1:0] YEL_LAST      = TW'(YEL - 1);
  localparam logic [TW-1:0] ALLRED_LAST   = TW'(ALLRED - 1);
  // Phase 0 never latches demand, so its bit is masked off everywhere.
  localparam logic [NUM_PHASES-1:0] NONMAIN_MASK = ~NUM_PHASES'(1);

  state_t                    state_q, state_d;
  logic [2:0]                phase_q, phase_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NUM_PHASES-1:0]     demand_q, demand_d;
  logic                      peak_lat_q, peak_lat_d;
  logic [2*NUM_PHASES-1:0]   lights_q, lights_d, lights_rst;
  logic                      cycle_start_q, cycle_start_d;

  logic [NUM_PHASES-1:0]     is_cur, is_next;
  logic                      minor_cur;
  logic [TW-1:0]             green_last;
  logic [2:0]                next_off, next_peak, next_sel;
  logic                      demand_any;
  logic                      enter_green;

  // Per-phase decode of current/next phase, light bus and demand update.
  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
      assign is_cur[gi]  = (phase_q == 3'(gi));
      assign is_next[gi] = (phase_d == 3'(gi));
      assign lights_d[2*gi +: 2]   = is_next[gi] ? state_d : 2'd2;
      assign lights_rst[2*gi +: 2] = (gi == 0) ? 2'd0 : 2'd2;
      if (gi == 0) begin : g_main
        assign demand_d[gi] = 1'b0;
      end else begin : g_side
        // Clearing on GREEN entry wins; a sensor still high afterwards re-latches.
        assign demand_d[gi] = (enter_green && is_next[gi]) ? 1'b0
                                                           : (demand_q[gi] | sensor[gi]);
      end
    end
  endgenerate

  assign minor_cur  = |(is_cur & MINOR_MASK);
  // Current sensor levels count too, so a pulse ends main-road rest on the next edge.
  assign demand_any = |((demand_q | sensor) & NONMAIN_MASK);
  assign next_peak  = (phase_q == 3'(NUM_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
  assign next_sel   = peak_lat_q ? next_peak : next_off;

  // Green length for the phase being served, from the mode latched at its entry.
  always_comb begin
    case ({peak_lat_q, minor_cur})
      2'b11:   green_last = GP_MINOR_LAST;
      2'b10:   green_last = GP_LAST;
      2'b01:   green_last = GO_MINOR_LAST;
      default: green_last = GO_LAST;
    endcase
  end

  // Off-peak choice: lowest demanding phase above the current one, else main road.
  always_comb begin
    next_off = 3'd0;
    for (int i = NUM_PHASES - 1; i >= 1; i--) begin
      if (demand_q[i] && (3'(i) > phase_q)) next_off = 3'(i);
    end
  end

  // Next-state logic: timer-driven GREEN -> YELLOW -> ALLRED -> GREEN(next).
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    timer_d       = timer_q + 1'b1;
    peak_lat_d    = peak_lat_q;
    cycle_start_d = 1'b0;
    enter_green   = 1'b0;
    case (state_q)
      ST_GREEN: begin
        if (timer_q == green_last) begin
          if (!peak_lat_q && (phase_q == 3'd0) && !demand_any) begin
            timer_d = timer_q;  // main-road rest: hold with saturated timer
          end else begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end
        end
      end
      ST_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = ST_ALLRED;
          timer_d = '0;
        end
      end
      ST_ALLRED: begin
        if (timer_q == ALLRED_LAST) begin
          state_d       = ST_GREEN;
          phase_d       = next_sel;
          timer_d       = '0;
          peak_lat_d    = peak;
          enter_green   = 1'b1;
          cycle_start_d = (next_sel == 3'd0);
        end
      end
      default: begin
        // Unreachable encoding: fall back to a safe all-red clearance.
        state_d = ST_ALLRED;
        timer_d = '0;
      end
    endcase
  end

  // State, timer, demand and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_GREEN;
      phase_q       <= 3'd0;
      timer_q       <= '0;
      demand_q      <= '0;
      peak_lat_q    <= peak;
      lights_q      <= lights_rst;
      cycle_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      timer_q       <= timer_d;
      demand_q      <= demand_d;
      peak_lat_q    <= peak_lat_d;
      lights_q      <= lights_d;
      cycle_start_q <= cycle_start_d;
    end
  end

  assign lights      = lights_q;
  assign phase       = phase_q;
  assign state       = state_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_tlc_phase_seq.sv
// Bench for tlc_phase_seq: directed scenarios plus randomized traffic, all
// checked cycle by cycle against an elapsed-time reference model.
module tb_tlc_phase_seq;

  localparam int NP = 3;
  localparam int YEL_LEN = 4;
  localparam int AR_LEN  = 4;
  localparam logic [NP-1:0] MINOR = 3'b100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          peak = 1'b1;
  logic [NP-1:0] sensor = '0;
  logic [2*NP-1:0] lights;
  logic [2:0]    phase;
  logic [1:0]    state;
  logic          cycle_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: phase, state (0/1/2), cycles already spent in state.
  int m_phase, m_st, m_age;
  bit m_plat, m_cs;
  bit m_dem [NP];

  tlc_phase_seq dut (
    .clk(clk), .reset(reset), .peak(peak), .sensor(sensor),
    .lights(lights), .phase(phase), .state(state), .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int glen(input int ph, input bit pl);
    int g;
    g = pl ? 32 : 16;
    if (MINOR[ph]) g = g / 2;
    return g;
  endfunction

  task automatic model_step(input bit rst, input bit pk, input logic [NP-1:0] sen);
    int dur, nxt, entering;
    bit any;
    if (rst) begin
      m_phase = 0; m_st = 0; m_age = 0; m_plat = pk; m_cs = 0;
      for (int i = 0; i < NP; i++) m_dem[i] = 0;
      return;
    end
    m_cs = 0;
    entering = -1;
    dur = (m_st == 0) ? glen(m_phase, m_plat) : ((m_st == 1) ? YEL_LEN : AR_LEN);
    any = 0;
    for (int i = 1; i < NP; i++) if (m_dem[i] || sen[i]) any = 1;
    if (m_age + 1 < dur) begin
      m_age++;
    end else if (m_st == 0 && m_phase == 0 && !m_plat && !any) begin
      m_age = dur - 1;  // main road rests
    end else if (m_st < 2) begin
      m_st++;
      m_age = 0;
    end else begin
      nxt = 0;
      if (m_plat) nxt = (m_phase + 1) % NP;
      else for (int i = NP - 1; i > m_phase; i--) if (m_dem[i]) nxt = i;
      m_phase = nxt; m_st = 0; m_age = 0; m_plat = pk; m_cs = (nxt == 0);
      entering = nxt;
    end
    for (int i = 1; i < NP; i++) begin
      if (i == entering) m_dem[i] = 0;
      else if (sen[i]) m_dem[i] = 1;
    end
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic tick(input bit rst, input bit pk, input logic [NP-1:0] sen);
    logic [2*NP-1:0] exp_l;
    int nonred;
    reset = rst; peak = pk; sensor = sen;
    model_step(rst, pk, sen);
    @(posedge clk);
    #1;
    if (rst) cyc = 0; else cyc++;
    for (int i = 0; i < NP; i++) exp_l[2*i +: 2] = (i == m_phase) ? 2'(m_st) : 2'd2;
    nonred = 0;
    for (int i = 0; i < NP; i++) if (lights[2*i +: 2] != 2'd2) nonred++;
    check("lights", 32'(lights), 32'(exp_l));
    check("phase", 32'(phase), 32'(m_phase));
    check("state", 32'(state), 32'(m_st));
    check("cstart", 32'(cycle_start), 32'(m_cs));
    check("one_nonred", 32'(nonred <= 1), 32'd1);
  endtask

  task automatic expect_ps(input string tag, input int ph, input int st);
    check({tag, "_ph"}, 32'(phase), 32'(ph));
    check({tag, "_st"}, 32'(state), 32'(st));
  endtask

  initial begin
    // Reset values
    tick(1, 1, '0);
    check("rst_lights", 32'(lights), 32'(6'b101000));
    check("rst_cs", 32'(cycle_start), 32'd0);
    expect_ps("rst", 0, 0);

    // Peak round-robin cycle
    while (cyc < 110) begin
      tick(0, 1, '0);
      case (cyc)
        31:  expect_ps("pk31", 0, 0);
        32:  expect_ps("pk32", 0, 1);
        36:  expect_ps("pk36", 0, 2);
        40:  expect_ps("pk40", 1, 0);
        80:  expect_ps("pk80", 2, 0);
        96:  expect_ps("pk96", 2, 1);
        104: begin expect_ps("pk104", 0, 0); check("pk104_cs", 32'(cycle_start), 32'd1); end
        105: check("pk105_cs", 32'(cycle_start), 32'd0);
        default: ;
      endcase
    end

    // Off-peak main-road rest, released by a one-cycle sensor[1] pulse
    tick(1, 0, '0);
    while (cyc < 230) begin
      tick(0, 0, (cyc == 200) ? 3'b010 : 3'b000);
      case (cyc)
        200: expect_ps("rest200", 0, 0);
        201: expect_ps("rest201", 0, 1);
        209: expect_ps("rest209", 1, 0);
        225: expect_ps("rest225", 1, 1);
        default: ;
      endcase
    end

    // Skip phase 1: only phase 2 asked, minor green of 8
    tick(1, 0, '0);
    while (cyc < 70) begin
      tick(0, 0, (cyc == 2) ? 3'b100 : 3'b000);
      case (cyc)
        15: expect_ps("skip15", 0, 0);
        16: expect_ps("skip16", 0, 1);
        24: expect_ps("skip24", 2, 0);
        32: expect_ps("skip32", 2, 1);
        40: check("skip40_cs", 32'(cycle_start), 32'd1);
        65: expect_ps("skip65", 0, 0);
        default: ;
      endcase
    end

    // Sensor held through phase 2 green re-latches demand
    tick(1, 0, '0);
    while (cyc < 70) begin
      tick(0, 0, (cyc >= 2 && cyc <= 31) ? 3'b100 : 3'b000);
      case (cyc)
        24: expect_ps("hold24", 2, 0);
        56: expect_ps("hold56", 0, 1);
        64: expect_ps("hold64", 2, 0);
        default: ;
      endcase
    end

    // Mode change mid-green
    tick(1, 1, '0);
    while (cyc < 60) begin
      tick(0, cyc < 10, '0);
      case (cyc)
        31: expect_ps("mode31", 0, 0);
        32: expect_ps("mode32", 0, 1);
        55: expect_ps("mode55", 1, 0);
        56: expect_ps("mode56", 1, 1);
        default: ;
      endcase
    end

    // Reset during phase 1 yellow
    tick(1, 1, '0);
    while (cyc < 73) tick(0, 1, '0);
    expect_ps("midyel", 1, 1);
    tick(1, 1, '0);
    check("rstyel_lights", 32'(lights), 32'(6'b101000));
    check("rstyel_cs", 32'(cycle_start), 32'd0);
    expect_ps("rstyel", 0, 0);

    // Randomized traffic with occasional mode flips and resets
    begin
      bit pk;
      logic [NP-1:0] sen;
      pk = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 199) == 0) pk = ~pk;
        for (int i = 0; i < NP; i++) sen[i] = ($urandom_range(0, 24) == 0);
        tick($urandom_range(0, 799) == 0, pk, sen);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
